// File: rtl/shift_pkg.sv
// Shared encodings for the parameterised shift register: mode select codes
// and the burst controller state type.
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SR   = 3'b001;
    localparam logic [2:0] MODE_SL   = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASL  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } burst_state_t;

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: counts out a requested number of single-bit shifts and
// tells the datapath when and which way to shift.
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int LENW = 4
) (
    input  logic            cp,
    input  logic            cr_,
    input  logic            burst_go,
    input  logic            burst_dir,
    input  logic [LENW-1:0] burst_len,
    output logic            shift_en,
    output logic            shift_dir,
    output logic            busy,
    output logic            done
);

    burst_state_t    state;
    logic [LENW-1:0] cnt;
    logic            dir_q;

    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge cp or negedge cr_) begin
        if (!cr_) begin
            state <= IDLE;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (burst_go) begin
                        cnt   <= burst_len;
                        dir_q <= burst_dir;
                        state <= (burst_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == LENW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign shift_en  = (state == RUN);
    assign shift_dir = dir_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: rtl/param_shift_register.sv
// Universal shift register with mode-selected shift/rotate/load and a
// counted burst shift; Q[0] is the first stage, "right" moves toward MSB.
module param_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LENW  = $clog2(WIDTH) + 1
) (
    input  logic             cp,
    input  logic             cr_,
    input  logic [2:0]       mode,
    input  logic             sr,
    input  logic             sl,
    input  logic [WIDTH-1:0] d,
    input  logic             burst_go,
    input  logic             burst_dir,
    input  logic [LENW-1:0]  burst_len,
    output logic [WIDTH-1:0] Q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic shift_en;
    logic shift_dir;

    shift_burst_ctrl #(
        .LENW (LENW)
    ) u_ctrl (
        .cp        (cp),
        .cr_       (cr_),
        .burst_go  (burst_go),
        .burst_dir (burst_dir),
        .burst_len (burst_len),
        .shift_en  (shift_en),
        .shift_dir (shift_dir),
        .busy      (busy),
        .done      (done)
    );

    // A burst request in IDLE always starts a burst, so it pre-empts mode.
    always_ff @(posedge cp or negedge cr_) begin
        if (!cr_) begin
            Q <= '0;
        end else if (shift_en) begin
            Q <= shift_dir ? {sl, Q[WIDTH-1:1]} : {Q[WIDTH-2:0], sr};
        end else if (!busy && !burst_go) begin
            case (mode)
                MODE_SR:   Q <= {Q[WIDTH-2:0], sr};
                MODE_SL:   Q <= {sl, Q[WIDTH-1:1]};
                MODE_LOAD: Q <= d;
                MODE_ROR:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                MODE_ROL:  Q <= {Q[0], Q[WIDTH-1:1]};
                MODE_ASL:  Q <= {Q[WIDTH-1], Q[WIDTH-1:1]};
                default:   Q <= Q;
            endcase
        end
    end

    assign sout_r = Q[WIDTH-1];
    assign sout_l = Q[0];

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register (WIDTH=8): vector table, hand-written burst
// and reset sequences, randomized ops/bursts against an arithmetic model.
module tb_param_shift_register;
    import shift_pkg::*;

    localparam int W  = 8;
    localparam int LW = $clog2(W) + 1;

    logic          cp = 1'b0;
    logic          cr_;
    logic [2:0]    mode, mode2;
    logic          sr, sl, burst_go, burst_dir;
    logic [W-1:0]  d;
    logic [LW-1:0] burst_len;
    logic [W-1:0]  q, q2;
    logic          sout_r, sout_l, busy, done;
    logic          sout_r2, sout_l2, busy2, done2;

    param_shift_register #(.WIDTH(W)) dut (
        .cp(cp), .cr_(cr_), .mode(mode), .sr(sr), .sl(sl), .d(d),
        .burst_go(burst_go), .burst_dir(burst_dir), .burst_len(burst_len),
        .Q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    param_shift_register #(.WIDTH(W)) dut2 (
        .cp(cp), .cr_(cr_), .mode(mode2), .sr(sout_r), .sl(1'b0), .d('0),
        .burst_go(1'b0), .burst_dir(1'b0), .burst_len('0),
        .Q(q2), .sout_r(sout_r2), .sout_l(sout_l2), .busy(busy2), .done(done2)
    );

    always #5 cp = ~cp;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]   mode;
        logic         sr;
        logic         sl;
        logic [W-1:0] d;
        logic [W-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name, input logic [W-1:0] exp);
        check({name, ".Q"}, 32'(q), 32'(exp));
        check({name, ".sout_r"}, 32'(sout_r), 32'(exp[W-1]));
        check({name, ".sout_l"}, 32'(sout_l), 32'(exp[0]));
    endtask

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    // Reference: registers treated as integers 0..255, bit i has weight 2**i.
    function automatic logic [W-1:0] model_op(input logic [W-1:0] qv, input logic [2:0] m,
                                              input logic s_r, input logic s_l,
                                              input logic [W-1:0] dv);
        int v;
        v = int'(qv);
        case (m)
            3'd1: v = (v * 2 + int'(s_r)) % 256;
            3'd2: v = v / 2 + int'(s_l) * 128;
            3'd3: v = int'(dv);
            3'd4: v = (v * 2) % 256 + v / 128;
            3'd5: v = v / 2 + (v % 2) * 128;
            3'd6: v = v / 2 + (v / 128) * 128;
            default: v = v;
        endcase
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] model_burst(input logic [W-1:0] qv, input int n,
                                                 input logic dir, input logic s_r,
                                                 input logic s_l);
        int v;
        v = int'(qv);
        for (int i = 0; i < n; i++) begin
            if (dir) v = v / 2 + int'(s_l) * 128;
            else     v = (v * 2 + int'(s_r)) % 256;
        end
        return v[W-1:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         vecs[12];
        logic [W-1:0] qm, expv;
        int           k, len;

        vecs[0]  = '{MODE_LOAD, 1'b0, 1'b0, 8'hAA, 8'hAA};
        vecs[1]  = '{MODE_SR,   1'b1, 1'b0, 8'h00, 8'h55};
        vecs[2]  = '{MODE_SL,   1'b0, 1'b1, 8'h00, 8'hAA};
        vecs[3]  = '{MODE_LOAD, 1'b0, 1'b0, 8'h81, 8'h81};
        vecs[4]  = '{MODE_ROR,  1'b0, 1'b0, 8'h00, 8'h03};
        vecs[5]  = '{MODE_LOAD, 1'b0, 1'b0, 8'h80, 8'h80};
        vecs[6]  = '{MODE_ASL,  1'b0, 1'b0, 8'h00, 8'hC0};
        vecs[7]  = '{MODE_HOLD, 1'b1, 1'b1, 8'hFF, 8'hC0};
        vecs[8]  = '{MODE_RSVD, 1'b1, 1'b1, 8'hFF, 8'hC0};
        vecs[9]  = '{MODE_ROL,  1'b0, 1'b0, 8'h00, 8'h60};
        vecs[10] = '{MODE_SL,   1'b1, 1'b0, 8'h00, 8'h30};
        vecs[11] = '{MODE_SR,   1'b0, 1'b1, 8'h00, 8'h60};

        cr_ = 1'b0; mode = MODE_HOLD; mode2 = MODE_HOLD; sr = 1'b0; sl = 1'b0;
        d = '0; burst_go = 1'b0; burst_dir = 1'b0; burst_len = '0;
        #12;
        check_q("reset", 8'h00);
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        @(negedge cp);
        cr_ = 1'b1;
        step();
        check_q("post_reset_hold", 8'h00);

        foreach (vecs[i]) begin
            mode = vecs[i].mode; sr = vecs[i].sr; sl = vecs[i].sl; d = vecs[i].d;
            step();
            check_q($sformatf("vec%0d", i), vecs[i].exp);
        end
        mode = MODE_HOLD;

        // Burst right by 3 from 00000001, with a load attempted while busy.
        mode = MODE_LOAD; d = 8'h01; step(); mode = MODE_HOLD;
        burst_go = 1'b1; burst_dir = 1'b0; burst_len = 4'd3; sr = 1'b0;
        step();
        burst_go = 1'b0; mode = MODE_LOAD; d = 8'hFF;
        check_q("b3_launch", 8'h01);
        check("b3_launch.busy", 32'(busy), 1);
        step(); check_q("b3_s1", 8'h02); check("b3_s1.done", 32'(done), 0);
        step(); check_q("b3_s2", 8'h04); check("b3_s2.busy", 32'(busy), 1);
        step(); check_q("b3_done", 8'h08);
        check("b3_done.done", 32'(done), 1);
        check("b3_done.busy", 32'(busy), 1);
        step(); check_q("b3_idle", 8'h08);
        check("b3_idle.busy", 32'(busy), 0);
        check("b3_idle.done", 32'(done), 0);
        mode = MODE_HOLD;

        // Zero-length burst.
        burst_go = 1'b1; burst_len = 4'd0; sr = 1'b1;
        step(); burst_go = 1'b0;
        check_q("b0_done", 8'h08);
        check("b0_done.done", 32'(done), 1);
        step();
        check("b0_idle.busy", 32'(busy), 0);
        check("b0_idle.done", 32'(done), 0);

        // Length beyond WIDTH: nine right shifts of ones into zero.
        mode = MODE_LOAD; d = 8'h00; step(); mode = MODE_HOLD;
        burst_go = 1'b1; burst_dir = 1'b0; burst_len = 4'd9; sr = 1'b1;
        step(); burst_go = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin step(); k++; end
        check("b9_cycles", 32'(k), 9);
        check_q("b9_done", 8'hFF);
        step();

        // Burst request together with a load: burst wins, d never lands.
        mode = MODE_LOAD; d = 8'h3C; step();
        burst_go = 1'b1; burst_dir = 1'b1; burst_len = 4'd1; sl = 1'b0;
        mode = MODE_LOAD; d = 8'hAA;
        step(); burst_go = 1'b0; mode = MODE_HOLD;
        check_q("bgo_load_launch", 8'h3C);
        step();
        check_q("bgo_load_done", 8'h1E);
        check("bgo_load_done.done", 32'(done), 1);
        step();

        // Reset asserted mid-burst.
        mode = MODE_LOAD; d = 8'hF0; step(); mode = MODE_HOLD;
        burst_go = 1'b1; burst_dir = 1'b0; burst_len = 4'd5; sr = 1'b1;
        step(); burst_go = 1'b0;
        step();
        cr_ = 1'b0;
        #1;
        check_q("mid_rst_async", 8'h00);
        check("mid_rst_async.busy", 32'(busy), 0);
        check("mid_rst_async.done", 32'(done), 0);
        step();
        check_q("mid_rst_held", 8'h00);
        cr_ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst.done", 32'(done), 0);
            check("post_rst.busy", 32'(busy), 0);
        end
        mode = MODE_LOAD; d = 8'h01; step(); mode = MODE_HOLD;
        burst_go = 1'b1; burst_dir = 1'b1; burst_len = 4'd2; sl = 1'b1;
        step(); burst_go = 1'b0;
        step(); check_q("post_rst_b_s1", 8'h80);
        step(); check_q("post_rst_b_done", 8'hC0);
        check("post_rst_b_done.done", 32'(done), 1);
        step();

        // Randomized mode operations.
        mode = MODE_LOAD; d = 8'($urandom); qm = d; step();
        for (int i = 0; i < 200; i++) begin
            mode = 3'($urandom_range(0, 7));
            sr = 1'($urandom); sl = 1'($urandom); d = 8'($urandom);
            expv = model_op(qm, mode, sr, sl, d);
            step();
            qm = expv;
            check_q("rand_op", qm);
        end
        mode = MODE_HOLD;

        // Randomized bursts with random modes issued while busy.
        for (int b = 0; b < 25; b++) begin
            len = $urandom_range(0, 11);
            burst_go = 1'b1; burst_dir = 1'($urandom); burst_len = LW'(len);
            sr = 1'($urandom); sl = 1'($urandom);
            mode = 3'($urandom_range(0, 7)); d = 8'($urandom);
            step();
            burst_go = 1'b0;
            k = 0;
            while (done !== 1'b1 && k < 40) begin
                mode = 3'($urandom_range(0, 7)); d = 8'($urandom);
                step(); k++;
            end
            check("rand_burst_cycles", 32'(k), 32'(len));
            qm = model_burst(qm, len, burst_dir, sr, sl);
            check_q("rand_burst_done", qm);
            mode = 3'($urandom_range(0, 7)); d = 8'($urandom);
            step();
            check("rand_burst_idle.busy", 32'(busy), 0);
            check_q("rand_burst_idle", qm);
            mode = MODE_HOLD;
        end

        // Cascade: eight right shifts move the first register into the second.
        mode = MODE_LOAD; d = 8'h5C; step();
        mode = MODE_SR; sr = 1'b0; mode2 = MODE_SR;
        repeat (8) step();
        mode = MODE_HOLD; mode2 = MODE_HOLD;
        check("cascade.q2", 32'(q2), 32'h5C);
        check_q("cascade.q1", 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_shift_register.md
PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be legal for any value >= 2.
REQ-002 Parameter LENW, default $clog2(WIDTH)+1, width of the burst length field.
REQ-003 cp  in  1  clock; all state SHALL update on the rising edge.
REQ-004 cr_  in  1  asynchronous, active-low reset (clear).
REQ-005 mode  in  3  operation select; encodings per REQ-011.
REQ-006 sr  in  1  serial input for shift-right.
REQ-007 sl  in  1  serial input for shift-left.
REQ-008 d  in  WIDTH  parallel load data.
REQ-009 burst_go, burst_dir, burst_len  in  1, 1, LENW  burst request pulse, direction (0=right, 1=left), shift count.
REQ-010 Q, sout_r, sout_l, busy, done  out  WIDTH, 1, 1, 1, 1  register contents, Q[WIDTH-1], Q[0], burst active, one-cycle burst-complete pulse.

Function
REQ-011 Index convention: Q[0] is stage A. "Right" moves data toward higher indices. Mode actions when not busy:
- 000 hold
- 001 shift right: Q <= {Q[W-2:0], sr}
- 010 shift left: Q <= {sl, Q[W-1:1]}
- 011 parallel load: Q <= d
- 100 rotate right: Q <= {Q[W-2:0], Q[W-1]}
- 101 rotate left: Q <= {Q[0], Q[W-1:1]}
- 110 arithmetic shift left: Q <= {Q[W-1], Q[W-1:1]}; MSB is preserved.
- 111 hold, reserved.
REQ-012 Each mode action SHALL take effect on the first rising edge after it is applied, with one-edge latency; Q SHALL be driven directly from flops.
REQ-013 sout_r SHALL equal Q[W-1] and sout_l SHALL equal Q[0] combinationally, so cascaded instances chain without an extra stage.
REQ-014 Burst FSM states:
- IDLE -> RUN on burst_go=1 while IDLE; the internal counter loads burst_len and the direction is latched.
- RUN: on each edge, perform one shift in the latched direction (sr/sl sampled live) and decrement the counter.
- RUN -> DONE when the counter reaches 1 and that shift is performed.
- DONE -> IDLE unconditionally after one cycle.
REQ-015 burst_go with burst_len=0 SHALL go IDLE->DONE with no shift.
REQ-016 busy SHALL be 1 in RUN and DONE; done SHALL be 1 only in DONE.
REQ-017 burst_go and mode SHALL be ignored while busy=1.
REQ-018 If burst_go=1 arrives in IDLE together with a non-hold mode, the burst SHALL win and the mode action on that edge SHALL be discarded.
REQ-019 burst_len values greater than WIDTH SHALL be honoured literally; for example, WIDTH+1 right shifts with sr=1 yields all ones.
REQ-020 No output SHALL be X after reset while inputs are known.

Reset
REQ-021 cr_=0 SHALL immediately force Q=0, the FSM to IDLE, the counter to 0, busy=0, and done=0, independent of cp.
REQ-022 Assertion of cr_ mid-burst SHALL abort the burst with no done pulse; release of cr_ SHALL take effect at the next rising edge.

Structure
REQ-023 Package shift_pkg SHALL hold the mode encodings (MODE_HOLD ... MODE_ASL) as localparams and the burst FSM state typedef (IDLE, RUN, DONE).
REQ-024 The burst FSM and counter SHALL be a single sub-module shift_burst_ctrl that outputs a shift-enable/direction pair to the datapath; the datapath stays in param_shift_register.

Verification (WIDTH=8)
REQ-025 Reset and load: cr_=0 then released, Q=00000000; mode=011 with d=10101010 -> Q=10101010 after one edge.
REQ-026 Shift and rotate: from 10101010, mode=001 with sr=1 -> 01010101; mode=010 with sl=1 -> 10101010; mode=100 on 10000001 -> 00000011; mode=110 on 10000000 -> 11000000.
REQ-027 Burst: Q=00000001, burst_go with dir=0, len=3, sr=0 -> busy for 4 cycles, Q=00001000 in DONE, a single done pulse, then IDLE; mode=011 during RUN is ignored.
REQ-028 Burst edges: len=0 gives done on the next cycle with Q unchanged; len=9 with sr=1 on Q=0 gives Q=11111111; burst_go together with mode=011 gives burst only, d not loaded.
REQ-029 Reset mid-burst: cr_ pulsed low during RUN -> Q=0 and busy=0 asynchronously, no done pulse; a new burst after release behaves normally.
REQ-030 Cascade: two instances with sout_r of the first wired to sr of the second, 8 right shifts -> the low byte of the first appears in the second.
